// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath control unit: sequences fetch/decode/execute/memory/writeback
// for R, I, load, store and branch instructions, traps on unknown opcodes and
// counts retired instructions.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   opcode[6:0]       - instruction opcode (stable from DECODE until next FETCH)
//   zero              - ALU zero flag, branch-taken condition
//   mem_ready         - memory acknowledge for the current mem_req
//   pc_write, ir_write- PC / IR load strobes (combinational on mem_ready / zero)
//   mem_req, mem_we, i_or_d, reg_write, alu_src_a, pc_src, mem_to_reg
//                     - registered datapath strobes and mux selects
//   alu_src_b[1:0]    - 00 reg, 01 const 4, 10 imm
//   alu_op[1:0]       - 00 add, 01 branch-compare, 10 funct-decode
//   state[3:0]        - current state code
//   illegal           - trap flag
//   instret[15:0]     - retired-instruction counter (wraps)
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic        pc_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [15:0] instret
);

    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t cur;
    state_t nxt;
    logic   retire;

    // Next-state values of the registered strobes, decoded from nxt so the
    // registered outputs line up with the state they belong to.
    logic       d_mem_req;
    logic       d_mem_we;
    logic       d_i_or_d;
    logic       d_reg_write;
    logic       d_alu_src_a;
    logic       d_pc_src;
    logic       d_mem_to_reg;
    logic [1:0] d_alu_src_b;
    logic [1:0] d_alu_op;
    logic       d_illegal;

    assign state = cur;

    // PC/IR load follow the handshake/flag within the cycle, so they stay combinational.
    assign ir_write = (cur == S_FETCH) && mem_ready;
    assign pc_write = ir_write || ((cur == S_BRANCH) && zero);

    // Next-state logic; retire marks a transition that completes an instruction.
    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        case (cur)
            S_IDLE:     nxt = S_FETCH;
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:      nxt = S_EXEC_R;
                    OP_I:      nxt = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  nxt = S_MEM_ADDR;
                    OP_BRANCH: nxt = S_BRANCH;
                    default:   nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) nxt = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_EXEC_R,
            S_EXEC_I:   nxt = S_WB_ALU;
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_TRAP;
        endcase
    end

    // Moore output decode of the state being entered.
    always_comb begin
        d_mem_req    = 1'b0;
        d_mem_we     = 1'b0;
        d_i_or_d     = 1'b0;
        d_reg_write  = 1'b0;
        d_alu_src_a  = 1'b0;
        d_pc_src     = 1'b0;
        d_mem_to_reg = 1'b0;
        d_alu_src_b  = 2'b00;
        d_alu_op     = 2'b00;
        d_illegal    = 1'b0;
        case (nxt)
            S_FETCH: begin
                d_mem_req   = 1'b1;
                d_alu_src_b = 2'b01;
            end
            S_DECODE:   d_alu_src_b = 2'b10;
            S_MEM_ADDR: begin
                d_alu_src_a = 1'b1;
                d_alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                d_mem_req = 1'b1;
                d_i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                d_mem_req = 1'b1;
                d_i_or_d  = 1'b1;
                d_mem_we  = 1'b1;
            end
            S_WB_MEM: begin
                d_reg_write  = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            S_WB_ALU:   d_reg_write = 1'b1;
            S_EXEC_R: begin
                d_alu_src_a = 1'b1;
                d_alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                d_alu_src_a = 1'b1;
                d_alu_src_b = 2'b10;
                d_alu_op    = 2'b10;
            end
            S_BRANCH: begin
                d_alu_src_a = 1'b1;
                d_alu_op    = 2'b01;
                d_pc_src    = 1'b1;
            end
            S_TRAP:     d_illegal = 1'b1;
            default: ;
        endcase
    end

    // State, registered strobes and retire counter; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= S_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            i_or_d     <= 1'b0;
            reg_write  <= 1'b0;
            alu_src_a  <= 1'b0;
            pc_src     <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src_b  <= 2'b00;
            alu_op     <= 2'b00;
            illegal    <= 1'b0;
            instret    <= '0;
        end else begin
            cur        <= nxt;
            mem_req    <= d_mem_req;
            mem_we     <= d_mem_we;
            i_or_d     <= d_i_or_d;
            reg_write  <= d_reg_write;
            alu_src_a  <= d_alu_src_a;
            pc_src     <= d_pc_src;
            mem_to_reg <= d_mem_to_reg;
            alu_src_b  <= d_alu_src_b;
            alu_op     <= d_alu_op;
            illegal    <= d_illegal;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table for one instruction
// of each class, then directed trap, async-reset and counter-wrap sequences.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write;
    logic        alu_src_a, pc_src, mem_to_reg, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state;
    logic [15:0] instret;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_src(pc_src),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    // {pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write, alu_src_a, pc_src,
    //  mem_to_reg, alu_src_b[1:0], alu_op[1:0], illegal}
    logic [13:0] outs;
    assign outs = {pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write, alu_src_a,
                   pc_src, mem_to_reg, alu_src_b, alu_op, illegal};

    localparam logic [13:0] PW      = 14'b10_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] IW      = 14'b01_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] O_IDLE  = 14'b00_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] O_FETCH = 14'b00_1_0_0_0_0_0_0_01_00_0;
    localparam logic [13:0] O_DEC   = 14'b00_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] O_MADDR = 14'b00_0_0_0_0_1_0_0_10_00_0;
    localparam logic [13:0] O_MRD   = 14'b00_1_0_1_0_0_0_0_00_00_0;
    localparam logic [13:0] O_MWR   = 14'b00_1_1_1_0_0_0_0_00_00_0;
    localparam logic [13:0] O_WBM   = 14'b00_0_0_0_1_0_0_1_00_00_0;
    localparam logic [13:0] O_WBA   = 14'b00_0_0_0_1_0_0_0_00_00_0;
    localparam logic [13:0] O_EXR   = 14'b00_0_0_0_0_1_0_0_00_10_0;
    localparam logic [13:0] O_EXI   = 14'b00_0_0_0_0_1_0_0_10_10_0;
    localparam logic [13:0] O_BR    = 14'b00_0_0_0_0_1_1_0_00_01_0;
    localparam logic [13:0] O_TRAP  = 14'b00_0_0_0_0_0_0_0_00_00_1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [6:0]  opc;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [13:0] out;
        logic [15:0] ir;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    function automatic vec_t v(input logic [6:0] opc, input logic z, input logic rdy,
                               input logic [3:0] st, input logic [13:0] out,
                               input logic [15:0] ir);
        vec_t r;
        r.opc = opc; r.z = z; r.rdy = rdy; r.st = st; r.out = out; r.ir = ir;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: inputs for the cycle and the expected state/outputs in that cycle.
        tbl[0]  = v(OP_R,  1'b0, 1'b1, 4'd0,  O_IDLE,            16'd0);
        tbl[1]  = v(OP_R,  1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd0);
        tbl[2]  = v(OP_R,  1'b0, 1'b1, 4'd2,  O_DEC,             16'd0);
        tbl[3]  = v(OP_R,  1'b0, 1'b1, 4'd7,  O_EXR,             16'd0);
        tbl[4]  = v(OP_R,  1'b0, 1'b1, 4'd9,  O_WBA,             16'd0);
        tbl[5]  = v(OP_LD, 1'b0, 1'b0, 4'd1,  O_FETCH,           16'd1);
        tbl[6]  = v(OP_LD, 1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd1);
        tbl[7]  = v(OP_LD, 1'b0, 1'b1, 4'd2,  O_DEC,             16'd1);
        tbl[8]  = v(OP_LD, 1'b0, 1'b0, 4'd3,  O_MADDR,           16'd1);
        tbl[9]  = v(OP_LD, 1'b0, 1'b0, 4'd4,  O_MRD,             16'd1);
        tbl[10] = v(OP_LD, 1'b0, 1'b0, 4'd4,  O_MRD,             16'd1);
        tbl[11] = v(OP_LD, 1'b0, 1'b1, 4'd4,  O_MRD,             16'd1);
        tbl[12] = v(OP_LD, 1'b0, 1'b0, 4'd5,  O_WBM,             16'd1);
        tbl[13] = v(OP_ST, 1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd2);
        tbl[14] = v(OP_ST, 1'b0, 1'b1, 4'd2,  O_DEC,             16'd2);
        tbl[15] = v(OP_ST, 1'b0, 1'b1, 4'd3,  O_MADDR,           16'd2);
        tbl[16] = v(OP_ST, 1'b0, 1'b1, 4'd6,  O_MWR,             16'd2);
        tbl[17] = v(OP_I,  1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd3);
        tbl[18] = v(OP_I,  1'b0, 1'b1, 4'd2,  O_DEC,             16'd3);
        tbl[19] = v(OP_I,  1'b0, 1'b1, 4'd8,  O_EXI,             16'd3);
        tbl[20] = v(OP_I,  1'b0, 1'b1, 4'd9,  O_WBA,             16'd3);
        tbl[21] = v(OP_BR, 1'b1, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd4);
        tbl[22] = v(OP_BR, 1'b1, 1'b1, 4'd2,  O_DEC,             16'd4);
        tbl[23] = v(OP_BR, 1'b1, 1'b1, 4'd10, O_BR | PW,         16'd4);
        tbl[24] = v(OP_BR, 1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd5);
        tbl[25] = v(OP_BR, 1'b0, 1'b1, 4'd2,  O_DEC,             16'd5);
        tbl[26] = v(OP_BR, 1'b0, 1'b1, 4'd10, O_BR,              16'd5);
        tbl[27] = v(OP_BAD,1'b0, 1'b1, 4'd1,  O_FETCH | PW | IW, 16'd6);
        tbl[28] = v(OP_BAD,1'b0, 1'b1, 4'd2,  O_DEC,             16'd6);
        tbl[29] = v(OP_BAD,1'b0, 1'b1, 4'd11, O_TRAP,            16'd6);

        rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(outs), 32'(O_IDLE));
        chk("reset instret", 32'(instret), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table walk: R, stalled fetch, load with 2 wait cycles, store, I, branch taken/not, illegal.
        for (int i = 0; i < NVEC; i++) begin
            opcode = tbl[i].opc; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d outs", i), 32'(outs), 32'(tbl[i].out));
            chk($sformatf("vec%0d instret", i), 32'(instret), 32'(tbl[i].ir));
            @(negedge clk);
        end

        // TRAP is absorbing: no memory requests regardless of inputs.
        for (int i = 0; i < 10; i++) begin
            opcode = (i % 2 == 0) ? OP_R : OP_LD;
            mem_ready = 1'b1; zero = 1'b1;
            #1;
            chk($sformatf("trap%0d state", i), 32'(state), 32'd11);
            chk($sformatf("trap%0d outs", i), 32'(outs), 32'(O_TRAP));
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("trap reset state", 32'(state), 32'd0);
        chk("trap reset illegal", 32'(illegal), 32'd0);
        chk("trap reset instret", 32'(instret), 32'd0);

        // Store stalled in MEM_WR, then async reset mid-cycle.
        @(negedge clk);
        rst = 1'b0; opcode = OP_ST; mem_ready = 1'b1; zero = 1'b0;
        repeat (4) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("stall memwr state", 32'(state), 32'd6);
        chk("stall memwr req/we", 32'({mem_req, mem_we}), 32'b11);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst state", 32'(state), 32'd0);
        chk("async rst req/we", 32'({mem_req, mem_we, i_or_d}), 32'b000);
        chk("async rst outs", 32'(outs), 32'(O_IDLE));

        // Counter wrap: preload 0xFFFF, retire one store.
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        force dut.instret = 16'hFFFF;
        #1;
        release dut.instret;
        #1;
        chk("preload instret", 32'(instret), 32'h0000FFFF);
        repeat (4) @(negedge clk);
        #1;
        chk("wrap memwr state", 32'(state), 32'd6);
        chk("wrap before", 32'(instret), 32'h0000FFFF);
        @(negedge clk);
        #1;
        chk("wrap fetch state", 32'(state), 32'd1);
        chk("wrap after", 32'(instret), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
